// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer.
// One full-adder cell is fed LSB-first, one bit per clock, from operand shift
// registers. The sum is assembled MSB-in in a shift register and published to
// Sum/Cout only on the edge that enters DONE.
// Optional feature macro: SERIAL_ADD_OVF_EN (adds the Ovf signed-overflow port).

// Single-bit full-adder cell.
module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             Ovf
`endif
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sha_q, shb_q;
    logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic               cout_q;
    logic [CNT_W-1:0]   count_q;
    logic               fa_s, fa_co;
    logic               accept, last_bit;
`ifdef SERIAL_ADD_OVF_EN
    logic               ovf_q;
`endif

    assign accept   = In_Valid && In_Ready;
    assign last_bit = (count_q == CNT_W'(WIDTH - 1));

    fa u_fa (
        .a_i  (sha_q[0]),
        .b_i  (shb_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    // Sum shift register next value: FA sum bit enters at the MSB.
    always_comb begin
        sum_sh_d            = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1]   = fa_s;
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (!Rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        In_Ready  = (state_q == S_IDLE) && Rst_n;
        Out_Valid = (state_q == S_DONE);
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  if (Out_Ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operand load, per-bit shift, and result capture on the last bit.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            sha_q    <= '0;
            shb_q    <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            count_q  <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        sha_q   <= A;
                        shb_q   <= B;
                        carry_q <= Cin;
                        count_q <= '0;
                    end
                end
                S_RUN: begin
                    sha_q    <= sha_q >> 1;
                    shb_q    <= shb_q >> 1;
                    sum_sh_q <= sum_sh_d;
                    carry_q  <= fa_co;
                    count_q  <= count_q + CNT_W'(1);
                    if (last_bit) begin
                        sum_q  <= sum_sh_d;
                        cout_q <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                        // carry_q here is the carry into the MSB.
                        ovf_q  <= carry_q ^ fa_co;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl, WIDTH=8 and WIDTH=1 instances.
module tb_serial_add_ctrl;
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Rst_n;
    logic       iv8, ir8, ov8, or8, cin8, co8;
    logic [7:0] a8, b8, s8;
    logic       iv1, ir1, ov1, or1, cin1, co1;
    logic [0:0] a1, b1, s1;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf8, ovf1;
`endif

    int ncmp = 0;
    int nerr = 0;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .Clk(Clk), .Rst_n(Rst_n), .In_Valid(iv8), .In_Ready(ir8),
        .A(a8), .B(b8), .Cin(cin8), .Out_Valid(ov8), .Out_Ready(or8),
        .Sum(s8), .Cout(co8)
`ifdef SERIAL_ADD_OVF_EN
        , .Ovf(ovf8)
`endif
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .In_Valid(iv1), .In_Ready(ir1),
        .A(a1), .B(b1), .Cin(cin1), .Out_Valid(ov1), .Out_Ready(or1),
        .Sum(s1), .Cout(co1)
`ifdef SERIAL_ADD_OVF_EN
        , .Ovf(ovf1)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // One WIDTH=8 operation: exact latency, result, optional backpressure and busy poke.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input int hold, input bit poke);
        logic [8:0] exp;
        int         sv;
        logic       expo;
        exp  = 9'(a) + 9'(b) + 9'(c);
        sv   = int'($signed(a)) + int'($signed(b)) + int'(c);
        expo = (sv > 127) || (sv < -128);
        chk("in_ready8_idle", 64'(ir8), 64'(1));
        iv8 = 1'b1; a8 = a; b8 = b; cin8 = c; or8 = 1'b0;
        cyc();
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        for (int i = 1; i <= 8; i++) begin
            if (poke && i == 3) begin iv8 = 1'b1; a8 = 8'hAA; end
            if (poke && i == 4) iv8 = 1'b0;
            cyc();
            chk("out_valid8_lat", 64'(ov8), 64'(i == 8));
            chk("in_ready8_busy", 64'(ir8), 64'(0));
        end
        chk("sum8", 64'(s8), 64'(exp[7:0]));
        chk("cout8", 64'(co8), 64'(exp[8]));
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf8", 64'(ovf8), 64'(expo));
`else
        if (expo) ; // signed overflow only observable with the Ovf port
`endif
        for (int h = 0; h < hold; h++) begin
            cyc();
            chk("out_valid8_hold", 64'(ov8), 64'(1));
            chk("in_ready8_hold", 64'(ir8), 64'(0));
            chk("sum8_hold", 64'({co8, s8}), 64'(exp));
        end
        or8 = 1'b1;
        cyc();
        or8 = 1'b0;
        chk("out_valid8_drop", 64'(ov8), 64'(0));
        chk("in_ready8_back", 64'(ir8), 64'(1));
    endtask

    // One WIDTH=1 operation.
    task automatic op1(input logic a, input logic b, input logic c, input int hold);
        logic [1:0] exp;
        int         sv;
        logic       expo;
        exp  = 2'(a) + 2'(b) + 2'(c);
        sv   = (a ? -1 : 0) + (b ? -1 : 0) + int'(c);
        expo = (sv > 0) || (sv < -1);
        chk("in_ready1_idle", 64'(ir1), 64'(1));
        iv1 = 1'b1; a1 = a; b1 = b; cin1 = c; or1 = 1'b0;
        cyc();
        iv1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
        cyc();
        chk("out_valid1_lat", 64'(ov1), 64'(1));
        chk("result1", 64'({co1, s1}), 64'(exp));
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf1", 64'(ovf1), 64'(expo));
`else
        if (expo) ;
`endif
        for (int h = 0; h < hold; h++) begin
            cyc();
            chk("result1_hold", 64'({ov1, co1, s1}), 64'({1'b1, exp}));
        end
        or1 = 1'b1;
        cyc();
        or1 = 1'b0;
        chk("in_ready1_back", 64'({ir1, ov1}), 64'(2'b10));
    endtask

    initial begin
        Rst_n = 1'b0;
        iv8 = 0; or8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        iv1 = 0; or1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        cyc(); cyc();
        // Reset state
        chk("rst_in_ready8", 64'(ir8), 64'(0));
        chk("rst_out_valid8", 64'(ov8), 64'(0));
        chk("rst_result8", 64'({co8, s8}), 64'(0));
        chk("rst_in_ready1", 64'(ir1), 64'(0));
        chk("rst_result1", 64'({ov1, co1, s1}), 64'(0));
        Rst_n = 1'b1;
        @(negedge Clk);

        // Basic and carry ripple
        op8(8'h0F, 8'h01, 1'b0, 0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        // Backpressure
        op8(8'h5A, 8'h3C, 1'b1, 5, 1'b0);
        // Busy ignore, then no second result appears
        op8(8'h03, 8'h04, 1'b0, 0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("no_extra_result", 64'(ov8), 64'(0));
        end
        // Overflow corner cases
        op8(8'h7F, 8'h01, 1'b0, 0, 1'b0);
        op8(8'h80, 8'hFF, 1'b0, 0, 1'b0);
        op8(8'h10, 8'h20, 1'b0, 0, 1'b0);

        // Reset abort at RUN count==3 (previous result 8'h30 is nonzero)
        iv8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        cyc();
        iv8 = 1'b0;
        cyc(); cyc(); cyc();
        Rst_n = 1'b0;
        #1;
        chk("abort_in_ready_low", 64'(ir8), 64'(0));
        cyc();
        chk("abort_out_valid", 64'(ov8), 64'(0));
        chk("abort_result", 64'({co8, s8}), 64'(0));
        Rst_n = 1'b1;
        #1;
        chk("abort_idle", 64'(ir8), 64'(1));
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("abort_no_result", 64'(ov8), 64'(0));
        end
        op8(8'h21, 8'h43, 1'b1, 1, 1'b0);

        // Random ops, both widths
        for (int n = 0; n < 200; n++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b0);
        for (int n = 0; n < 200; n++)
            op1(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
